// File: rtl/fp16_divider.sv
// fp16_divider: multi-cycle IEEE-754 binary16 divider, C = A / B.
// Restoring division, one quotient bit per cycle; fixed 17-cycle latency
// from the accepting edge to the Valid pulse. Round-to-nearest-even,
// subnormal outputs flush to zero, subnormal inputs are supported.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   A, B   - dividend / divisor, sampled on the accepting edge
//   Ready  - request; accepted on any rising edge where Busy=0
//   Busy   - high from the accepting edge until the edge raising Valid
//   C      - quotient, held until the next result
//   Valid  - one-cycle pulse marking a new C
module fp16_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Ready,
  output logic        Busy,
  output logic [15:0] C,
  output logic        Valid
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_NORM, S_DIV, S_ROUND} state_t;

  state_t             state_q;
  logic [15:0]        a_q, b_q, c_q;
  logic               busy_q, valid_q, sign_q;
  logic               a_zero_q, a_inf_q, a_nan_q, b_zero_q, b_inf_q, b_nan_q;
  logic signed [7:0]  expa_q, expb_q, e_q;
  logic [10:0]        siga_q, sigb_q;
  logic [11:0]        rem_q;
  logic [13:0]        quo_q;
  logic [3:0]         cnt_q;

  // Left-shift amount that brings the leading one of a significand to bit 10.
  function automatic logic [3:0] lead_shift(input logic [10:0] s);
    logic [3:0] sh;
    sh = '0;
    for (int unsigned i = 0; i < 11; i++)
      if (s[i]) sh = 4'(10 - i);
    return sh;
  endfunction

  // Operand classification from the latched inputs
  logic [4:0]        ea_f, eb_f;
  logic              ua_zero, ua_inf, ua_nan, ub_zero, ub_inf, ub_nan;
  logic signed [7:0] ua_exp, ub_exp;
  logic [10:0]       ua_sig, ub_sig;

  assign ea_f    = a_q[14:10];
  assign eb_f    = b_q[14:10];
  assign ua_zero = (ea_f == 5'd0)  && (a_q[9:0] == 10'd0);
  assign ua_inf  = (ea_f == 5'd31) && (a_q[9:0] == 10'd0);
  assign ua_nan  = (ea_f == 5'd31) && (a_q[9:0] != 10'd0);
  assign ub_zero = (eb_f == 5'd0)  && (b_q[9:0] == 10'd0);
  assign ub_inf  = (eb_f == 5'd31) && (b_q[9:0] == 10'd0);
  assign ub_nan  = (eb_f == 5'd31) && (b_q[9:0] != 10'd0);
  assign ua_exp  = (ea_f == 5'd0) ? -8'sd14 : ($signed({3'b000, ea_f}) - 8'sd15);
  assign ub_exp  = (eb_f == 5'd0) ? -8'sd14 : ($signed({3'b000, eb_f}) - 8'sd15);
  assign ua_sig  = {(ea_f != 5'd0), a_q[9:0]};
  assign ub_sig  = {(eb_f != 5'd0), b_q[9:0]};

  // Normalisation of subnormal significands
  logic [3:0]        sha, shb;
  logic [10:0]       na_sig, nb_sig;
  logic signed [7:0] na_exp, nb_exp;

  assign sha    = lead_shift(siga_q);
  assign shb    = lead_shift(sigb_q);
  assign na_sig = siga_q << sha;
  assign nb_sig = sigb_q << shb;
  assign na_exp = expa_q - $signed({4'b0000, sha});
  assign nb_exp = expb_q - $signed({4'b0000, shb});

  // One restoring-division step
  logic [12:0] trial;
  logic        qbit;
  logic [11:0] rem_d;
  logic [13:0] quo_d;

  assign trial = {1'b0, rem_q} - {2'b00, sigb_q};
  assign qbit  = ~trial[12];
  assign rem_d = (qbit ? trial[11:0] : rem_q) << 1;
  assign quo_d = {quo_q[12:0], qbit};

  // Rounding, range handling and special-case override
  logic [9:0]        frac_raw, frac_r;
  logic              g_bit, s_bit, up, carry;
  logic signed [7:0] e_adj, e_r;
  logic [15:0]       c_d;

  always_comb begin
    if (quo_q[13]) begin
      frac_raw = quo_q[12:3];
      g_bit    = quo_q[2];
      s_bit    = (|quo_q[1:0]) | (|rem_q);
      e_adj    = e_q;
    end else begin
      frac_raw = quo_q[11:2];
      g_bit    = quo_q[1];
      s_bit    = quo_q[0] | (|rem_q);
      e_adj    = e_q - 8'sd1;
    end
    up     = g_bit & (s_bit | frac_raw[0]);
    // An all-ones fraction rounding up wraps to zero: significand becomes 1.0.
    carry  = up & (&frac_raw);
    frac_r = frac_raw + {9'd0, up};
    e_r    = carry ? (e_adj + 8'sd1) : e_adj;

    if (e_r > 8'sd15)
      c_d = {sign_q, 5'h1F, 10'd0};
    else if (e_r < -8'sd14)
      c_d = {sign_q, 15'd0};
    else
      c_d = {sign_q, 5'(e_r + 8'sd15), frac_r};

    if (a_nan_q || b_nan_q || (a_zero_q && b_zero_q) || (a_inf_q && b_inf_q))
      c_d = 16'h7E00;
    else if (a_inf_q || b_zero_q)
      c_d = {sign_q, 5'h1F, 10'd0};
    else if (a_zero_q || b_inf_q)
      c_d = {sign_q, 15'd0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sign_q   <= 1'b0;
      a_zero_q <= 1'b0;
      a_inf_q  <= 1'b0;
      a_nan_q  <= 1'b0;
      b_zero_q <= 1'b0;
      b_inf_q  <= 1'b0;
      b_nan_q  <= 1'b0;
      expa_q   <= '0;
      expb_q   <= '0;
      e_q      <= '0;
      siga_q   <= '0;
      sigb_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Ready) begin
            a_q     <= A;
            b_q     <= B;
            busy_q  <= 1'b1;
            state_q <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_q   <= a_q[15] ^ b_q[15];
          a_zero_q <= ua_zero;
          a_inf_q  <= ua_inf;
          a_nan_q  <= ua_nan;
          b_zero_q <= ub_zero;
          b_inf_q  <= ub_inf;
          b_nan_q  <= ub_nan;
          expa_q   <= ua_exp;
          expb_q   <= ub_exp;
          siga_q   <= ua_sig;
          sigb_q   <= ub_sig;
          state_q  <= S_NORM;
        end
        S_NORM: begin
          siga_q  <= na_sig;
          sigb_q  <= nb_sig;
          e_q     <= na_exp - nb_exp;
          rem_q   <= {1'b0, na_sig};
          quo_q   <= '0;
          cnt_q   <= '0;
          state_q <= S_DIV;
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) state_q <= S_ROUND;
        end
        S_ROUND: begin
          c_q     <= c_d;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy  = busy_q;
  assign C     = c_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_fp16_divider.sv
// tb_fp16_divider: self-checking bench for fp16_divider. Random and directed
// operands are compared against a real-arithmetic binary16 reference model.
module tb_fp16_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A, B;
  logic        Ready;
  logic        Busy;
  logic [15:0] C;
  logic        Valid;

  int checks   = 0;
  int failures = 0;

  fp16_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Ready (Ready),
    .Busy  (Busy),
    .C     (C),
    .Valid (Valid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real mag(input logic [15:0] x);
    int f, m;
    f = int'(x[14:10]);
    m = int'(x[9:0]);
    if (f == 0) return real'(m) * pow2(-24);
    return real'(m + 1024) * pow2(f - 25);
  endfunction

  function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    logic s, an, ai, az, bn, bi, bz;
    real q, m, fr;
    int e, f;
    logic [4:0] ef;
    logic [9:0] mf;
    s  = a[15] ^ b[15];
    an = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
    ai = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
    az = (a[14:0] == 15'd0);
    bn = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
    bi = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
    bz = (b[14:0] == 15'd0);
    if (an || bn || (az && bz) || (ai && bi)) return 16'h7E00;
    if (ai || bz) return {s, 15'h7C00};
    if (az || bi) return {s, 15'h0000};
    q = mag(a) / mag(b);
    e = 0;
    while (q >= 2.0) begin q = q / 2.0; e++; end
    while (q < 1.0)  begin q = q * 2.0; e--; end
    m  = q * 1024.0;
    f  = $rtoi(m);
    fr = m - real'(f);
    if (fr > 0.5 || (fr == 0.5 && (f % 2) == 1)) f++;
    if (f == 2048) begin f = 1024; e++; end
    if (e > 15)  return {s, 15'h7C00};
    if (e < -14) return {s, 15'h0000};
    ef = 5'(e + 15);
    mf = 10'(f - 1024);
    return {s, ef, mf};
  endfunction

  function automatic logic [15:0] pick_operand();
    logic [15:0] sp [9];
    sp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
           16'h0001, 16'h03FF, 16'h7BFF, 16'h3C00};
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
      2:       return sp[$urandom_range(0, 8)];
      default: return {1'($urandom), 5'd0, 10'($urandom)};
    endcase
  endfunction

  // Issue one request (DUT must be idle); returns result and edges to Valid.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] c, output int lat);
    @(negedge clk);
    A = a; B = b; Ready = 1'b1;
    @(posedge clk); #1;
    Ready = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    lat = 0;
    while (!Valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    c = C;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] c;
    int lat;
    rst_n = 1'b0; Ready = 1'b0; A = '0; B = '0;
    #23;
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Valid); end
    checks++; if (C !== 16'h0000) begin failures++; $display("FAIL reset_c got=%h exp=0000", C); end
    @(posedge clk); #1; rst_n = 1'b1;
    run_op(16'h3C00, 16'h4000, c, lat);
    checks++; if (c !== 16'h3800) begin failures++; $display("FAIL first_after_reset_c got=%h exp=3800", c); end
    checks++; if (lat !== 17) begin failures++; $display("FAIL first_after_reset_lat got=%0d exp=17", lat); end
  endtask

  task automatic test_handshake();
    int busy_cnt = 0, valid_cnt = 0, valid_at = -1;
    logic overlap = 1'b0;
    logic [15:0] cval = '0;
    @(negedge clk);
    A = 16'h3C00; B = 16'h4000; Ready = 1'b1;
    @(posedge clk); #1;
    Ready = 1'b0; A = 16'h4200; B = 16'h3C00;
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (Busy) busy_cnt++;
      if (Valid) begin
        valid_cnt++; valid_at = k; cval = C;
        if (Busy) overlap = 1'b1;
      end
    end
    checks++; if (busy_cnt !== 17) begin failures++; $display("FAIL busy_cycles got=%0d exp=17", busy_cnt); end
    checks++; if (valid_cnt !== 1) begin failures++; $display("FAIL valid_pulses got=%0d exp=1", valid_cnt); end
    checks++; if (valid_at !== 17) begin failures++; $display("FAIL valid_latency got=%0d exp=17", valid_at); end
    checks++; if (cval !== 16'h3800) begin failures++; $display("FAIL handshake_c got=%h exp=3800", cval); end
    checks++; if (overlap !== 1'b0) begin failures++; $display("FAIL busy_during_valid got=%b exp=0", overlap); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [10] = '{16'h3C00, 16'h4200, 16'h0200, 16'h3C00, 16'h0000,
                             16'h8000, 16'h7C00, 16'hBC00, 16'h7BFF, 16'h0001};
    logic [15:0] tb [10] = '{16'h4200, 16'h3C00, 16'h3800, 16'h0000, 16'h0000,
                             16'h3C00, 16'h7C00, 16'h7C00, 16'h0001, 16'h7BFF};
    logic [15:0] te [10] = '{16'h3555, 16'h4200, 16'h0400, 16'h7C00, 16'h7E00,
                             16'h8000, 16'h7E00, 16'h8000, 16'h7C00, 16'h0000};
    logic [15:0] c;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(ta[i], tb[i], c, lat);
      checks++;
      if (c !== te[i] || lat !== 17) begin
        failures++;
        $display("FAIL directed_%0d A=%h B=%h got=%h lat=%0d exp=%h lat=17", i, ta[i], tb[i], c, lat, te[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, c, e;
    int lat;
    for (int i = 0; i < 120; i++) begin
      a = pick_operand();
      b = pick_operand();
      e = ref_div(a, b);
      run_op(a, b, c, lat);
      checks++;
      if (c !== e) begin failures++; $display("FAIL random_c A=%h B=%h got=%h exp=%h", a, b, c, e); end
      checks++;
      if (lat !== 17) begin failures++; $display("FAIL random_lat A=%h B=%h got=%0d exp=17", a, b, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int pos [4];
    int nv = 0;
    logic cbad = 1'b0;
    @(negedge clk);
    A = 16'h4200; B = 16'h3C00; Ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 57; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (Valid) begin
        if (nv < 4) pos[nv] = k;
        nv++;
        if (C !== 16'h4200) cbad = 1'b1;
      end
    end
    Ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (nv !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", nv); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i < nv && pos[i] !== 17 + 18 * i) begin
        failures++; $display("FAIL b2b_pos_%0d got=%0d exp=%0d", i, pos[i], 17 + 18 * i);
      end else if (i >= nv) begin
        failures++; $display("FAIL b2b_pos_%0d got=none exp=%0d", i, 17 + 18 * i);
      end
    end
    checks++; if (cbad !== 1'b0) begin failures++; $display("FAIL b2b_c got=wrong exp=4200"); end
  endtask

  task automatic test_ready_while_busy();
    logic [15:0] c;
    int lat;
    logic early = 1'b0, extra = 1'b0;
    logic [15:0] hold_c = '0;
    logic vfinal;
    logic [15:0] cfinal;
    run_op(16'h4400, 16'h4000, c, lat);
    checks++; if (c !== 16'h4000) begin failures++; $display("FAIL rwb_setup_c got=%h exp=4000", c); end
    @(negedge clk);
    A = 16'h3C00; B = 16'h4000; Ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 17; k++) begin
      Ready = (k <= 15) ? 1'(k % 2) : 1'b0;
      A = 16'h4200; B = 16'h3C00;
      @(posedge clk); #1;
      if (k < 17 && (Valid || C !== 16'h4000)) begin early = 1'b1; hold_c = C; end
    end
    vfinal = Valid; cfinal = C;
    Ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (Valid) extra = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL rwb_hold got=%h exp=4000 no_valid", hold_c); end
    checks++; if (vfinal !== 1'b1) begin failures++; $display("FAIL rwb_valid got=%b exp=1", vfinal); end
    checks++; if (cfinal !== 16'h3800) begin failures++; $display("FAIL rwb_c got=%h exp=3800", cfinal); end
    checks++; if (extra !== 1'b0) begin failures++; $display("FAIL rwb_extra_valid got=%b exp=0", extra); end
  endtask

  task automatic test_reset_midop();
    logic [15:0] c;
    int lat;
    @(negedge clk);
    A = 16'h4200; B = 16'h4200; Ready = 1'b1;
    @(posedge clk); #1;
    Ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", Valid); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", Busy); end
    checks++; if (C !== 16'h0000) begin failures++; $display("FAIL midrst_c got=%h exp=0000", C); end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    run_op(16'h4400, 16'h4000, c, lat);
    checks++; if (c !== 16'h4000) begin failures++; $display("FAIL midrst_new_c got=%h exp=4000", c); end
    checks++; if (lat !== 17) begin failures++; $display("FAIL midrst_new_lat got=%0d exp=17", lat); end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_directed();
    test_random();
    test_back_to_back();
    test_ready_while_busy();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp16_divider.md
FP16_DIVIDER -- requirements
Module: fp16_divider

Interface
REQ-001 SHALL have no parameters; the format is fixed IEEE-754 binary16.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  16  dividend (binary16), sampled on the accepting edge only.
REQ-005 B  input  16  divisor (binary16), sampled on the accepting edge only.
REQ-006 Ready  input  1  operation request; accepted on any rising edge where Busy=0.
REQ-007 Busy  output  1  high from the accepting edge until the edge that raises Valid.
REQ-008 C  output  16  quotient A/B (binary16); holds its value until the next result.
REQ-009 Valid  output  1  one-cycle pulse; C is valid while Valid=1.

Function
REQ-010 SHALL implement the FSM IDLE -> UNPACK -> NORM -> DIV -> ROUND -> IDLE.
- IDLE -> UNPACK on an accepting edge.
- UNPACK, NORM and ROUND each take 1 cycle.
- DIV takes exactly 14 cycles, one quotient bit per cycle (restoring).
REQ-011 SHALL raise Valid exactly 17 rising edges after the accepting edge, for every input including special cases (fixed latency).
REQ-012 SHALL ignore Ready while Busy=1; no queuing of requests.
- Busy is low during the Valid cycle, so a Ready in that cycle is accepted.
REQ-013 UNPACK SHALL:
- compute sign = A[15]^B[15];
- classify each operand as zero, subnormal, normal, inf or NaN;
- form unbiased exponents (subnormal = -14) and 11-bit significands (hidden bit = 0 for subnormal).
REQ-014 NORM SHALL left-shift subnormal significands until bit10=1, decrementing the exponent by the shift count; exponent datapath is signed 7-bit minimum.
REQ-015 DIV SHALL compute:
- Q = floor((sigA<<13)/sigB), 14 bits;
- rem = final remainder (nonzero sets sticky);
- e = expA - expB.
REQ-016 Normalisation SHALL depend on Q[13]:
- Q[13]=1: mantissa Q[13:3], guard Q[2], sticky Q[1]|Q[0]|rem!=0;
- Q[13]=0: e=e-1, mantissa Q[12:2], guard Q[1], sticky Q[0]|rem!=0.
REQ-017 ROUND SHALL round to nearest even: round_up = G & (sticky | lsb).
- Mantissa carry-out yields significand 1.0 with e+1.
REQ-018 Range handling after rounding:
- e > 15 -> signed infinity {sign,11111,0};
- e < -14 -> signed zero (no subnormal outputs; flush-to-zero);
- otherwise {sign, e+15, mant[9:0]}.
REQ-019 Special cases SHALL take priority over REQ-018, in this order:
- any NaN, 0/0 or inf/inf -> 16'h7E00;
- inf/finite or nonzero-finite/0 -> signed infinity;
- 0/nonzero or finite/inf -> signed zero.
REQ-020 Signed zero inputs SHALL be treated as zero; the result sign is always A[15]^B[15] except for NaN.

Reset
REQ-021 On rst_n=0 SHALL immediately force:
- FSM=IDLE, Busy=0, Valid=0, C=16'h0000;
- all datapath registers cleared.
REQ-022 Reset mid-operation SHALL discard the in-flight result; no Valid for it after release.
REQ-023 The first rising edge after rst_n deasserts SHALL be able to accept a request.

Verification
REQ-024 A=3C00, B=4000, Ready pulse -> Busy=1 for 17 cycles, Valid=1 for one cycle with C=3800.
REQ-025 A=3C00,B=4200 -> C=3555 (RNE).
- A=4200,B=3C00 -> C=4200.
- A=0200,B=3800 (subnormal input) -> C=0400.
REQ-026 Special cases:
- A=3C00,B=0000 -> 7C00;
- A=0000,B=0000 -> 7E00;
- A=8000,B=3C00 -> 8000;
- A=7C00,B=7C00 -> 7E00;
- A=BC00,B=7C00 -> 8000.
REQ-027 Range limits:
- A=7BFF,B=0001 -> 7C00 (overflow);
- A=0001,B=7BFF -> 0000 (underflow flush).
REQ-028 Handshake: Ready held high continuously -> accepted results every 18 cycles; Ready toggled while Busy -> no extra Valid, C unchanged.
REQ-029 Reset mid-op: rst_n low on cycle 5 of a DIV -> Valid, Busy and C all 0.
- After release, a new request A=4400,B=4000 -> C=4000 at latency 17.
